// File: rtl/sr_latch_ctrl.sv
// Arbitrates two write requesters onto one gated SR latch and sequences its
// setup, gate-pulse and hold phases, verifying q after every write.
module sr_latch_ctrl #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic op0,
  output logic ack0,
  input  logic req1,
  input  logic op1,
  output logic ack1,
  output logic c,
  output logic s,
  output logic r,
  input  logic q_fb,
  output logic busy,
  output logic err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] PULSE = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  // A zero parameter behaves as one cycle; the counter runs down to zero.
  localparam logic [3:0] S_LD = (SETUP_CYC == 0) ? 4'd0 : 4'(SETUP_CYC - 1);
  localparam logic [3:0] P_LD = (PULSE_CYC == 0) ? 4'd0 : 4'(PULSE_CYC - 1);
  localparam logic [3:0] H_LD = (HOLD_CYC  == 0) ? 4'd0 : 4'(HOLD_CYC  - 1);

  logic [2:0] state;
  logic [3:0] cnt;
  logic       op_q;
  logic       gnt;
  logic       last_grant;
  logic       pick;
  logic       pick_op;

  // On contention the port that did not win last time gets the latch.
  assign pick    = (req0 && req1) ? ~last_grant : req1;
  assign pick_op = pick ? op1 : op0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      op_q       <= 1'b0;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      c          <= 1'b0;
      s          <= 1'b0;
      r          <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt        <= pick;
            last_grant <= pick;
            op_q       <= pick_op;
            s          <= pick_op;
            r          <= ~pick_op;
            c          <= 1'b0;
            busy       <= 1'b1;
            cnt        <= S_LD;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == 4'd0) begin
            c     <= 1'b1;
            cnt   <= P_LD;
            state <= PULSE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        PULSE: begin
          if (cnt == 4'd0) begin
            c     <= 1'b0;
            cnt   <= H_LD;
            state <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (cnt == 4'd0) begin
            s     <= 1'b0;
            r     <= 1'b0;
            ack0  <= ~gnt;
            ack1  <= gnt;
            if (q_fb != op_q) err <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          c     <= 1'b0;
          s     <= 1'b0;
          r     <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Directed bench: default-parameter controller on a zero-delay latch model,
// plus a second instance with stretched timing parameters.
module tb_sr_latch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
  logic ack0, ack1, c, s, r, busy, err;
  logic q_a, q_fb_a;
  logic bad = 1'b0;

  logic req_b = 1'b0, op_b = 1'b0;
  logic ack0_b, ack1_b, c_b, s_b, r_b, busy_b, err_b, q_b;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] cv, sv, rv, a0v, a1v, errv, cbv, sbv, a0bv, bbv;

  always #5 clk = ~clk;

  sr_latch_ctrl dut_a (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .ack0(ack0),
    .req1(req1), .op1(op1), .ack1(ack1),
    .c(c), .s(s), .r(r), .q_fb(q_fb_a),
    .busy(busy), .err(err)
  );

  sr_latch_ctrl #(.SETUP_CYC(0), .PULSE_CYC(3), .HOLD_CYC(2)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req_b), .op0(op_b), .ack0(ack0_b),
    .req1(1'b0), .op1(1'b0), .ack1(ack1_b),
    .c(c_b), .s(s_b), .r(r_b), .q_fb(q_b),
    .busy(busy_b), .err(err_b)
  );

  // Zero-delay gated SR latch models.
  always_latch begin
    if (c && s) q_a = 1'b1;
    else if (c && r) q_a = 1'b0;
  end
  always_latch begin
    if (c_b && s_b) q_b = 1'b1;
    else if (c_b && r_b) q_b = 1'b0;
  end
  assign q_fb_a = bad ? 1'b0 : q_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Record cycles 1..n (bit k = cycle k) counted from the next rising edge.
  task automatic trace(input int n, input bit drop);
    cv = '0; sv = '0; rv = '0; a0v = '0; a1v = '0; errv = '0;
    cbv = '0; sbv = '0; a0bv = '0; bbv = '0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      cv[k] = c; sv[k] = s; rv[k] = r; a0v[k] = ack0; a1v[k] = ack1; errv[k] = err;
      cbv[k] = c_b; sbv[k] = s_b; a0bv[k] = ack0_b; bbv[k] = busy_b;
      if (drop) begin
        if (ack0) req0 = 1'b0;
        if (ack1) req1 = 1'b0;
        if (ack0_b) req_b = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("s_r_excl", {30'd0, s & r, s_b & r_b}, 32'd0);
      chk("s_r_stable_c", {31'd0, c & ~(s ^ r)}, 32'd0);
    end
  end

  initial begin
    // reset then single set on port 0
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {25'd0, c, s, r, ack0, ack1, busy, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0; req0 = 1'b1; op0 = 1'b1;
    trace(6, 1'b1);
    chk("set_c", cv, 32'h0C);
    chk("set_s", sv, 32'h1E);
    chk("set_r", rv, 32'h00);
    chk("set_ack0", a0v, 32'h20);
    chk("set_q", {31'd0, q_a}, 32'd1);
    chk("set_err", {31'd0, err}, 32'd0);

    // single reset on port 1
    req1 = 1'b1; op1 = 1'b0;
    trace(6, 1'b1);
    chk("rst1_r", rv, 32'h1E);
    chk("rst1_s", sv, 32'h00);
    chk("rst1_c", cv, 32'h0C);
    chk("rst1_ack1", a1v, 32'h20);
    chk("rst1_ack0", a0v, 32'h00);
    chk("rst1_q", {31'd0, q_a}, 32'd0);

    // contention: both held high from reset
    @(negedge clk);
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; op0 = 1'b1; op1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    trace(24, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_ack0", a0v, 32'h0002_0020);
    chk("rr_ack1", a1v, 32'h0080_0800);
    chk("rr_s", sv, 32'h0001_E01E);
    chk("rr_r", rv, 32'h0078_0780);

    // stretched parameters on the second instance
    req_b = 1'b1; op_b = 1'b1;
    trace(8, 1'b1);
    chk("par_c", cbv, 32'h1C);
    chk("par_s", sbv, 32'h7E);
    chk("par_ack", a0bv, 32'h80);
    chk("par_busy", bbv, 32'hFE);
    chk("par_q", {31'd0, q_b}, 32'd1);

    // verify failure is sticky until reset
    bad = 1'b1; req0 = 1'b1; op0 = 1'b1;
    trace(6, 1'b1);
    chk("vf_err", errv, 32'h60);
    bad = 1'b0; req1 = 1'b1; op1 = 1'b0;
    trace(6, 1'b1);
    chk("vf_sticky", errv, 32'h7E);
    chk("vf_ack1", a1v, 32'h20);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("vf_clear", {31'd0, err}, 32'd0);

    // reset during PULSE abandons the write
    @(negedge clk);
    rst = 1'b0; req0 = 1'b1; op0 = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("mid_pulse_c", {31'd0, c}, 32'd1);
    rst = 1'b1; req0 = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_outs", {27'd0, c, s, r, busy, ack0}, 32'd0);
    @(negedge clk);
    rst = 1'b0; req0 = 1'b1; op0 = 1'b1;
    trace(6, 1'b1);
    chk("after_ack0", a0v, 32'h20);
    chk("after_c", cv, 32'h0C);
    chk("after_q", {31'd0, q_a}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sr_latch_ctrl.md
# sr_latch_ctrl

Sequencing controller and two-port arbiter for a shared gated SR latch (`sr_latch_nand_gated`). It grants one requester at a time and drives the latch's gate and data inputs through a setup, gate-pulse and hold sequence. It never presents the forbidden s=r=1 combination and checks the latch output after every write. It sits between requester logic and the latch, and it is the only block that drives the latch's `c`, `s` and `r`.

## Interface
Parameters:
- SETUP_CYC, 1, cycles s/r are held stable with the gate low before the pulse (1..15; 0 is treated as 1)
- PULSE_CYC, 2, cycles the gate `c` is high (1..15; 0 is treated as 1)
- HOLD_CYC, 1, cycles s/r are held with the gate low after the pulse (1..15; 0 is treated as 1)

Ports:
- clk  in  1  single clock; all logic is on its rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 write request; held high until ack0
- op0  in  1  requester 0 operation: 1 = set (q→1), 0 = reset (q→0)
- ack0  out  1  one-cycle completion pulse to requester 0
- req1  in  1  requester 1 write request; held high until ack1
- op1  in  1  requester 1 operation, same encoding as op0
- ack1  out  1  one-cycle completion pulse to requester 1
- c  out  1  latch gate
- s  out  1  latch set input
- r  out  1  latch reset input
- q_fb  in  1  latch q, fed back for write verification
- busy  out  1  high in every state except IDLE
- err  out  1  sticky write-verify failure flag

## Operation
- All outputs are registered.
- Reset values: c=0, s=0, r=0, ack0=0, ack1=0, busy=0, err=0. The state returns to IDLE, last_grant=1 (so req0 wins the first contention), and counters are cleared.
- States: IDLE → SETUP → PULSE → HOLD → DONE → IDLE.
- IDLE:
  - Samples req0 and req1.
  - If only one is high, that requester is granted. If both are high, the requester other than last_grant is granted.
  - On a grant, latch the granted op into op_q, update last_grant, load the counter and go to SETUP.
  - If no request is high, stay in IDLE.
- SETUP: c=0, s=op_q, r=~op_q for SETUP_CYC cycles, then go to PULSE.
- PULSE: c=1, s and r unchanged, for PULSE_CYC cycles, then go to HOLD.
- HOLD:
  - c=0, s and r unchanged, for HOLD_CYC cycles.
  - In the last HOLD cycle, compare q_fb with op_q. On a mismatch, set err; it stays set until rst.
  - Then go to DONE.
- DONE: c=s=r=0, and ack for the granted requester is high for exactly this one cycle. Then go to IDLE.
- Invariants:
  - s and r are never both 1.
  - c=1 only in PULSE.
  - s and r never change while c=1.
- A change on op0 or op1 after the grant is ignored; op_q is frozen for the whole transaction.
- A request arriving while busy waits; it is evaluated in the next IDLE cycle.
- Counter: 4-bit down-counter, loaded with (param==0 ? 1 : param) − 1 on state entry. The state advances when the counter reads 0.

## Timing
- Cycle 0 is the IDLE cycle in which the request is sampled. With S, P and H the effective parameter values:
  - SETUP occupies cycles 1..S.
  - PULSE occupies cycles S+1..S+P.
  - HOLD occupies cycles S+P+1..S+P+H.
  - DONE (ack high) is cycle S+P+H+1.
- With default parameters, ack is high in cycle 5 and the next grant is possible in cycle 6.
- Back-to-back: a requester must drop req in the cycle after ack. If req is still high in the following IDLE cycle, it is treated as a new request.
- Full-rate alternation: with both req0 and req1 held high, grants alternate 0,1,0,1…, one transaction per S+P+H+2 cycles.
- Reset mid-operation: on the rst edge the transaction is abandoned. No ack is issued, c, s and r go to 0 in the next cycle, and err is cleared.
- q_fb is treated as synchronous to clk. A latch model with zero delay satisfies the HOLD check.

## Test plan
- Reset then single set: rst=1 for 2 cycles, then req0=1, op0=1 with defaults → c=1 in cycles 2–3 only; s=1, r=0 in cycles 1–4; ack0=1 in cycle 5; q=1; err=0.
- Single reset on port 1: req1=1, op1=0 → r=1, s=0 during the sequence; ack1 in cycle 5; q=0; ack0 never asserted.
- Contention and round-robin: req0 and req1 both held high from reset → grant order 0,1,0,1; acks at cycles 5, 11, 17, 23; s&r==0 in every cycle.
- Parameters SETUP_CYC=0, PULSE_CYC=3, HOLD_CYC=2 → setup lasts 1 cycle, c is high for 3 cycles, hold lasts 2 cycles; ack in cycle 7.
- Verify failure: q_fb forced to 0 during a set → err=1 after HOLD, still 1 through later good writes, and 0 only after rst.
- Reset mid-operation: rst during PULSE → next cycle c=s=r=0, busy=0, no ack; a subsequent req0 completes normally with default latency.
